// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory port between the fetch stage (read-only) and the MEM stage
//           (read/write); data side has priority, fetch is forced after STARVE_LIMIT
//           consecutive data grants that overtook a pending fetch.
// Latency : request seen in IDLE at cycle 0 -> mem_req at 1 -> mem_ack at k -> ack at k+1.
// Backpressure: one access outstanding; requesters hold req/payload and stall until their ack.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_req/i_addr/i_rdata/i_ack fetch requester handshake
//   d_req/d_we/d_addr/d_wdata/d_strb/d_rdata/d_ack  data requester handshake
//   mem_req/we/addr/wdata/strb/rdata/ack  shared memory port
//   stall_fetch/stall_mem      per-requester stalls to the hazard unit
//   err                        sticky flag: mem_ack arrived while no access was waiting
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req_arb_i,
  input  logic [ADDR_W-1:0]   i_addr_arb_i,
  output logic [DATA_W-1:0]   i_rdata_arb_o,
  output logic                i_ack_arb_o,
  input  logic                d_req_arb_i,
  input  logic                d_we_arb_i,
  input  logic [ADDR_W-1:0]   d_addr_arb_i,
  input  logic [DATA_W-1:0]   d_wdata_arb_i,
  input  logic [DATA_W/8-1:0] d_strb_arb_i,
  output logic [DATA_W-1:0]   d_rdata_arb_o,
  output logic                d_ack_arb_o,
  output logic                mem_req_arb_o,
  output logic                mem_we_arb_o,
  output logic [ADDR_W-1:0]   mem_addr_arb_o,
  output logic [DATA_W-1:0]   mem_wdata_arb_o,
  output logic [DATA_W/8-1:0] mem_strb_arb_o,
  input  logic [DATA_W-1:0]   mem_rdata_arb_i,
  input  logic                mem_ack_arb_i,
  output logic                stall_fetch_arb_o,
  output logic                stall_mem_arb_o,
  output logic                err_arb_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic                owner_data_q;   // 1: current access belongs to the data side
  logic [CNT_W-1:0]    starve_cnt_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [STRB_W-1:0]   mem_strb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                i_ack_q;
  logic                d_ack_q;
  logic                err_q;

  logic fetch_forced;
  logic grant_data;
  logic grant_fetch;

  // Fetch overrides data priority once it has been overtaken STARVE_LIMIT times in a row.
  assign fetch_forced = i_req_arb_i && (starve_cnt_q == STARVE_MAX);
  assign grant_data   = d_req_arb_i && !fetch_forced;
  assign grant_fetch  = i_req_arb_i && !grant_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_data_q <= 1'b0;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_strb_q   <= '0;
      rdata_q      <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (mem_ack_arb_i && (state_q != WAIT)) begin
        err_q <= 1'b1;
      end
      // A fetch that is not waiting cannot be starving; later assignments below override.
      if (!i_req_arb_i) begin
        starve_cnt_q <= '0;
      end

      case (state_q)
        IDLE: begin
          if (grant_data) begin
            owner_data_q <= 1'b1;
            mem_req_q    <= 1'b1;
            mem_we_q     <= d_we_arb_i;
            mem_addr_q   <= d_addr_arb_i;
            mem_wdata_q  <= d_wdata_arb_i;
            mem_strb_q   <= d_we_arb_i ? d_strb_arb_i : '0;
            if (i_req_arb_i && (starve_cnt_q != STARVE_MAX)) begin
              starve_cnt_q <= starve_cnt_q + CNT_W'(1);
            end
            state_q      <= WAIT;
          end else if (grant_fetch) begin
            owner_data_q <= 1'b0;
            mem_req_q    <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= i_addr_arb_i;
            mem_wdata_q  <= '0;
            mem_strb_q   <= '0;
            starve_cnt_q <= '0;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ack_arb_i) begin
            mem_req_q <= 1'b0;
            rdata_q   <= mem_rdata_arb_i;
            i_ack_q   <= !owner_data_q;
            d_ack_q   <= owner_data_q;
            state_q   <= RESP;
          end
        end
        RESP: begin
          // Returning through IDLE gives the requester one cycle to retire its req.
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign i_rdata_arb_o     = rdata_q;
  assign d_rdata_arb_o     = rdata_q;
  assign i_ack_arb_o       = i_ack_q;
  assign d_ack_arb_o       = d_ack_q;
  assign mem_req_arb_o     = mem_req_q;
  assign mem_we_arb_o      = mem_we_q;
  assign mem_addr_arb_o    = mem_addr_q;
  assign mem_wdata_arb_o   = mem_wdata_q;
  assign mem_strb_arb_o    = mem_strb_q;
  assign err_arb_o         = err_q;
  assign stall_fetch_arb_o = i_req_arb_i && !i_ack_q;
  assign stall_mem_arb_o   = d_req_arb_i && !d_ack_q;

endmodule
